// File: rtl/stream_queue_bank_pkg.sv
// rtl/stream_queue_bank_pkg.sv - shared encodings and helpers for the stream queue bank
package stream_queue_bank_pkg;

  localparam int MODE_INDEP = 0;
  localparam int MODE_GANG  = 1;

  // Smallest r with 2**r >= value; constant-evaluated for sizing pointers.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - per-channel show-ahead queue of {e,d} tokens with slack back-pressure
module stream_fifo
  import stream_queue_bank_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int SLACK = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr_v,
  input  logic [W-1:0] wr_d,
  input  logic         wr_e,
  input  logic         rd_en,
  output logic [W-1:0] head_d,
  output logic         head_e,
  output logic         not_empty,
  output logic         in_b,
  output logic         drop
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH = CW'(DEPTH - SLACK);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [W:0]    mem_q [DEPTH];
  logic          rd, wr, full;

  // A read only happens on a non-empty queue, so a same-cycle write to an
  // empty queue never bypasses to the head.
  assign rd        = rd_en & (count_q != '0);
  assign full      = (count_q == FULL);
  assign wr        = wr_v & (~full | rd);
  assign drop      = wr_v & full & ~rd;
  assign not_empty = (count_q != '0);
  assign in_b      = reset | (count_q >= THRESH);
  assign head_d    = mem_q[rd_ptr_q][W-1:0];
  assign head_e    = mem_q[rd_ptr_q][W];

  always_comb begin
    count_d = count_q;
    if (wr && !rd)      count_d = count_q + CW'(1);
    else if (!wr && rd) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (wr) mem_q[wr_ptr_q] <= {wr_e, wr_d};
  end

endmodule

// File: rtl/stream_queue_bank.sv
// rtl/stream_queue_bank.sv - bank of per-channel stream queues with independent or ganged dequeue
module stream_queue_bank
  import stream_queue_bank_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int SLACK = 1,
  parameter int MODE  = MODE_INDEP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NCH*W-1:0] in_d,
  input  logic [NCH-1:0]   in_e,
  input  logic [NCH-1:0]   in_v,
  output logic [NCH-1:0]   in_b,
  output logic [NCH*W-1:0] out_d,
  output logic [NCH-1:0]   out_e,
  output logic [NCH-1:0]   out_v,
  input  logic [NCH-1:0]   out_b,
  output logic [NCH-1:0]   ovf
);

  localparam bit GANG = (MODE == MODE_GANG);

  logic [NCH*W-1:0] head_d, hold_d_q;
  logic [NCH-1:0]   head_e, hold_e_q;
  logic [NCH-1:0]   not_empty, drop, deq, vld, eos_err;
  logic [NCH-1:0]   ovf_q, ovf_d;
  logic             fire;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    stream_fifo #(
      .W     (W),
      .DEPTH (DEPTH),
      .SLACK (SLACK)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .wr_v      (in_v[i]),
      .wr_d      (in_d[i*W +: W]),
      .wr_e      (in_e[i]),
      .rd_en     (deq[i]),
      .head_d    (head_d[i*W +: W]),
      .head_e    (head_e[i]),
      .not_empty (not_empty[i]),
      .in_b      (in_b[i]),
      .drop      (drop[i])
    );

    // Outputs show the head while valid and keep the last shown token otherwise.
    assign out_d[i*W +: W] = reset  ? '0 :
                             vld[i] ? head_d[i*W +: W] : hold_d_q[i*W +: W];
    assign out_e[i]        = reset  ? 1'b0 :
                             vld[i] ? head_e[i] : hold_e_q[i];
  end

  always_comb begin
    fire    = 1'b0;
    vld     = not_empty;
    deq     = not_empty & ~out_b;
    eos_err = '0;
    if (GANG) begin
      fire = (&not_empty) & ~(|out_b);
      vld  = {NCH{&not_empty}};
      deq  = {NCH{fire}};
      // Heads that disagree on end-of-stream still fire; the e=1 lanes are marked.
      if (fire && !((&head_e) || !(|head_e))) eos_err = head_e;
    end
  end

  assign ovf_d = ovf_q | drop | eos_err;
  assign out_v = vld & {NCH{~reset}};
  assign ovf   = ovf_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q    <= '0;
      hold_d_q <= '0;
      hold_e_q <= '0;
    end else begin
      ovf_q    <= ovf_d;
      hold_d_q <= out_d;
      hold_e_q <= out_e;
    end
  end

endmodule

// File: tb/tb_stream_queue_bank.sv
// tb/tb_stream_queue_bank.sv - directed table and sequence bench for stream_queue_bank
module tb_stream_queue_bank;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic [127:0] a_in_d, a_out_d, b_in_d, b_out_d;
  logic [7:0]   a_in_e, a_in_v, a_in_b, a_out_e, a_out_v, a_out_b, a_ovf;
  logic [7:0]   b_in_e, b_in_v, b_in_b, b_out_e, b_out_v, b_out_b, b_ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_queue_bank #(.NCH(8), .W(16), .DEPTH(4), .SLACK(1), .MODE(0)) u_indep (
    .clock (clk),     .reset (rst),
    .in_d  (a_in_d),  .in_e  (a_in_e),  .in_v  (a_in_v),  .in_b (a_in_b),
    .out_d (a_out_d), .out_e (a_out_e), .out_v (a_out_v), .out_b (a_out_b),
    .ovf   (a_ovf)
  );

  stream_queue_bank #(.NCH(8), .W(16), .DEPTH(4), .SLACK(1), .MODE(1)) u_gang (
    .clock (clk),     .reset (rst),
    .in_d  (b_in_d),  .in_e  (b_in_e),  .in_v  (b_in_v),  .in_b (b_in_b),
    .out_d (b_out_d), .out_e (b_out_e), .out_v (b_out_v), .out_b (b_out_b),
    .ovf   (b_ovf)
  );

  typedef struct {
    logic        rst, v, e;
    logic [15:0] d;
    logic        ob;
    logic        xv, xb, xo;
    logic [15:0] xd;
    logic        xe;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, v, e, input logic [15:0] d, input logic ob,
                     input logic xv, xb, xo, input logic [15:0] xd, input logic xe);
    vec_t t;
    t.rst = r; t.v = v; t.e = e; t.d = d; t.ob = ob;
    t.xv = xv; t.xb = xb; t.xo = xo; t.xd = xd; t.xe = xe;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] exp_d;

  initial begin
    // Channel 0 of the independent instance; expectations are the state before each edge.
    add(0,0,0,16'h0000,1, 0,0,0,16'h0000,0);
    add(0,1,0,16'h1234,1, 0,0,0,16'h0000,0);
    add(0,0,0,16'h0000,1, 1,0,0,16'h1234,0);
    add(0,1,0,16'h1111,1, 1,0,0,16'h1234,0);
    add(0,1,0,16'h2222,1, 1,0,0,16'h1234,0);
    add(0,1,0,16'h3333,1, 1,1,0,16'h1234,0);
    add(0,1,0,16'h4444,1, 1,1,0,16'h1234,0);
    add(0,0,0,16'h0000,1, 1,1,1,16'h1234,0);
    add(0,0,0,16'h0000,0, 1,1,1,16'h1234,0);
    add(0,0,0,16'h0000,0, 1,1,1,16'h1111,0);
    add(0,0,0,16'h0000,0, 1,0,1,16'h2222,0);
    add(0,0,0,16'h0000,0, 1,0,1,16'h3333,0);
    add(0,0,0,16'h0000,0, 0,0,1,16'h3333,0);
    add(1,0,0,16'h0000,0, 0,1,0,16'h0000,0);
    add(0,1,0,16'h0A01,1, 0,0,0,16'h0000,0);
    add(0,1,0,16'h0A02,1, 1,0,0,16'h0A01,0);
    add(0,1,0,16'h0A03,1, 1,0,0,16'h0A01,0);
    add(0,1,0,16'h0A04,1, 1,1,0,16'h0A01,0);
    add(0,1,1,16'hAAAA,0, 1,1,0,16'h0A01,0);
    add(0,0,0,16'h0000,1, 1,1,0,16'h0A02,0);
    add(0,0,0,16'h0000,0, 1,1,0,16'h0A02,0);
    add(0,0,0,16'h0000,0, 1,1,0,16'h0A03,0);
    add(0,0,0,16'h0000,0, 1,0,0,16'h0A04,0);
    add(0,0,0,16'h0000,0, 1,0,0,16'hAAAA,1);
    add(0,0,0,16'h0000,0, 0,0,0,16'hAAAA,1);
    add(0,1,0,16'h5555,0, 0,0,0,16'hAAAA,1);
    add(0,0,0,16'h0000,1, 1,0,0,16'h5555,0);
    add(0,0,0,16'h0000,0, 1,0,0,16'h5555,0);
    add(0,0,0,16'h0000,0, 0,0,0,16'h5555,0);

    a_in_d = '0; a_in_e = '0; a_in_v = '0; a_out_b = '0;
    b_in_d = '0; b_in_e = '0; b_in_v = '0; b_out_b = '0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      rst        = tbl[i].rst;
      a_in_v     = {7'b0, tbl[i].v};
      a_in_e     = {7'b0, tbl[i].e};
      a_in_d     = '0;
      a_in_d[15:0] = tbl[i].d;
      a_out_b    = {7'b0, tbl[i].ob};
      @(negedge clk);
      chk($sformatf("vec%0d out_v", i), 128'(a_out_v[0]),     128'(tbl[i].xv));
      chk($sformatf("vec%0d in_b",  i), 128'(a_in_b[0]),      128'(tbl[i].xb));
      chk($sformatf("vec%0d ovf",   i), 128'(a_ovf[0]),       128'(tbl[i].xo));
      chk($sformatf("vec%0d out_d", i), 128'(a_out_d[15:0]),  128'(tbl[i].xd));
      chk($sformatf("vec%0d out_e", i), 128'(a_out_e[0]),     128'(tbl[i].xe));
      step();
    end
    a_in_v = '0; a_out_b = '0;

    // Gang: seven channels loaded, channel 7 empty -> nothing valid.
    b_in_v = 8'h7F;
    for (int c = 0; c < 8; c++) b_in_d[c*16 +: 16] = 16'h0100 + 16'(c);
    step();
    b_in_v = 8'h80;
    @(negedge clk);
    chk("gang partial out_v", 128'(b_out_v), 128'h00);
    step();
    b_in_v = 8'h00;
    @(negedge clk);
    for (int c = 0; c < 8; c++) exp_d[c*16 +: 16] = 16'h0100 + 16'(c);
    chk("gang full out_v", 128'(b_out_v), 128'hFF);
    chk("gang full out_d", b_out_d, exp_d);
    step();
    @(negedge clk);
    chk("gang after fire out_v", 128'(b_out_v), 128'h00);
    chk("gang after fire hold",  b_out_d, exp_d);
    chk("gang after fire ovf",   128'(b_ovf), 128'h00);

    // Only channel 7 written: if channels 0..6 drained, still not valid.
    b_in_v = 8'h80;
    b_in_d[127:112] = 16'h0207;
    step();
    b_in_v = 8'h00;
    @(negedge clk);
    chk("gang drained out_v", 128'(b_out_v), 128'h00);

    // EOS mismatch: channel 0 head has e=1, the rest e=0.
    step();
    b_in_v = 8'h7F;
    b_in_e = 8'h01;
    for (int c = 0; c < 7; c++) b_in_d[c*16 +: 16] = 16'h0300 + 16'(c);
    step();
    b_in_v = 8'h00;
    b_in_e = 8'h00;
    @(negedge clk);
    chk("eos out_v",  128'(b_out_v), 128'hFF);
    chk("eos out_e",  128'(b_out_e), 128'h01);
    chk("eos ch7 d",  128'(b_out_d[127:112]), 128'h0207);
    chk("eos pre ovf", 128'(b_ovf), 128'h00);
    step();
    @(negedge clk);
    chk("eos ovf",     128'(b_ovf), 128'h01);
    chk("eos out_v",   128'(b_out_v), 128'h00);

    // One downstream lane stalled blocks the whole gang.
    step();
    b_in_v  = 8'hFF;
    b_out_b = 8'h08;
    step();
    b_in_v  = 8'h00;
    @(negedge clk);
    chk("stall out_v a", 128'(b_out_v), 128'hFF);
    step();
    @(negedge clk);
    chk("stall out_v b", 128'(b_out_v), 128'hFF);
    chk("stall ovf",     128'(b_ovf), 128'h01);
    step();
    b_out_b = 8'h00;
    step();
    @(negedge clk);
    chk("stall released out_v", 128'(b_out_v), 128'h00);

    // Mid-stream reset with counts 2,3,4 on channels 0..2.
    a_out_b = 8'hFF;
    a_in_v  = 8'h07; step();
    a_in_v  = 8'h07; step();
    a_in_v  = 8'h06; step();
    a_in_v  = 8'h04; step();
    a_in_v  = 8'h00;
    @(negedge clk);
    chk("pre reset in_b",  128'(a_in_b),  128'h06);
    chk("pre reset out_v", 128'(a_out_v), 128'h07);
    #1;
    rst = 1'b1;
    #1;
    chk("reset in_b",  128'(a_in_b),  128'hFF);
    chk("reset out_v", 128'(a_out_v), 128'h00);
    chk("reset out_d", a_out_d, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post reset in_b",  128'(a_in_b),  128'h00);
    chk("post reset out_v", 128'(a_out_v), 128'h00);
    @(negedge clk);
    chk("post reset still empty", 128'(a_out_v), 128'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_queue_bank.md
STREAM_QUEUE_BANK -- requirements
Module: stream_queue_bank

Interface
REQ-001 Parameter NCH, default 8: number of stream channels, range 1..16.
REQ-002 Parameter W, default 16: data width per channel, range 1..64.
REQ-003 Parameter DEPTH, default 4: entries per channel queue; power of two, at least 2.
REQ-004 Parameter SLACK, default 1: free entries reserved for in-flight tokens; range 0..DEPTH-1.
REQ-005 Parameter MODE, default 0: 0 = independent channels, 1 = ganged (all-or-nothing) dequeue.
REQ-006 Port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port in_d, input, NCH*W bits: upstream data; channel i occupies bits [i*W +: W].
REQ-009 Port in_e, input, NCH bits: upstream end-of-stream flag, one per channel.
REQ-010 Port in_v, input, NCH bits: upstream token valid, one per channel.
REQ-011 Port in_b, output, NCH bits: back-pressure to upstream, one per channel.
REQ-012 Port out_d, output, NCH*W bits: downstream data, same channel packing as in_d.
REQ-013 Port out_e, output, NCH bits: downstream end-of-stream flag.
REQ-014 Port out_v, output, NCH bits: downstream token valid.
REQ-015 Port out_b, input, NCH bits: back-pressure from downstream.
REQ-016 Port ovf, output, NCH bits: sticky per-channel overflow flag.

Function
REQ-017 A token transfers on a port in any cycle where v=1 and b=0; e travels with d as one token.
REQ-018 Each channel SHALL hold a FIFO of DEPTH entries of {e,d}, with a count of 0..DEPTH.
REQ-019 in_b[i] = 1 when count[i] >= DEPTH-SLACK, decoded from registered count.
REQ-020 Write condition: the write SHALL succeed when in_v[i]=1 and count[i]<DEPTH, even if in_b[i]=1 (slack region).
REQ-021 Overflow: when in_v[i]=1, count[i]=DEPTH and no same-cycle dequeue, the token is dropped and ovf[i] sets and stays set.
REQ-022 Full with simultaneous dequeue: the write is accepted and the count is unchanged.
REQ-023 Latency: no bypass; a token written in cycle t SHALL appear on out_* no earlier than cycle t+1 (show-ahead head, 1-cycle latency).
REQ-024 MODE 0: out_v[i] = (count[i]>0); channel i dequeues when out_v[i]=1 and out_b[i]=0, independently of other channels.
REQ-025 MODE 1: fire = all count[i]>0 AND all out_b[i]=0; out_v[i]=1 for all i only while all counts>0; dequeue all channels together on fire, else none.
REQ-026 MODE 1, EOS mismatch: in a firing cycle where the head e bits disagree across channels, the block SHALL still fire and SHALL set ovf for the channels with e=1 (protocol error marker).
REQ-027 out_d and out_e SHALL be the head entry when out_v=1, and hold their last value otherwise.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 Simultaneous read and write on an empty channel: only the write takes effect.

Reset
REQ-030 While reset=1: counts, pointers and ovf = 0; out_v = 0; in_b = all ones (combinationally forced).
REQ-031 Reset asserted mid-stream SHALL discard all queued tokens; after deassertion, in_b follows REQ-019 from the next cycle.
REQ-032 FIFO storage contents need not be reset; out_d and out_e = 0 during reset.

Structure
REQ-033 A shared package SHALL hold the MODE encodings (MODE_INDEP=0, MODE_GANG=1) and a clog2 helper.
REQ-034 Per-channel queue SHALL be sub-module stream_fifo (params W, DEPTH, SLACK), instantiated NCH times.
REQ-035 Gang-fire and EOS-mismatch logic SHALL live in stream_queue_bank.

Verification
REQ-036 Basic latency (NCH=8, W=16, DEPTH=4, SLACK=1, MODE 0): write 0x1234 on channel 0 at cycle t -> out_v[0]=1 with out_d[15:0]=0x1234 at t+1.
REQ-037 Slack and overflow, out_b[0]=1: write 3 tokens -> in_b[0]=1; 4th write accepted; 5th dropped, ovf[0]=1, count stays 4.
REQ-038 Full with simultaneous read, channel 0 full: write 0xAAAA while out_b[0]=0 -> head dequeued, 0xAAAA queued, count stays 4, ovf[0]=0.
REQ-039 Gang (MODE 1): channels 0..6 each hold 1 token, channel 7 empty -> out_v=0x00; write channel 7 -> next cycle out_v=0xFF, one fire, all counts 0.
REQ-040 EOS mismatch (MODE 1): heads with in_e=0x01 fire -> ovf=0x01, all channels dequeued.
REQ-041 Reset mid-operation: assert reset with counts 2,3,4 -> in_b=0xFF and out_v=0 immediately; after release, counts 0 and in_b=0x00.
